// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci sequence generator.
package fib_pkg;

  localparam int unsigned FIB_WIDTH     = 6;
  localparam int unsigned FIB_IDX_W     = 8;
  localparam int unsigned CLK_PERIOD_NS = 10;

  typedef logic [FIB_WIDTH-1:0] term_t;

endpackage

// File: rtl/fibonacci_seq_if.sv
// Seed/term bundle for fibonacci_seq.
// Carries the ovf flag only when FIB_OVERFLOW_FLAG_EN is defined.
interface fibonacci_seq_if
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned IDX_W = FIB_IDX_W
);

  logic [WIDTH-1:0] f0;
  logic [WIDTH-1:0] f1;
  logic [WIDTH-1:0] fn;
  logic [IDX_W-1:0] idx;

`ifdef FIB_OVERFLOW_FLAG_EN
  logic ovf;

  modport master (output f0, f1, input fn, idx, ovf);
  modport slave  (input f0, f1, output fn, idx, ovf);
`else
  modport master (output f0, f1, input fn, idx);
  modport slave  (input f0, f1, output fn, idx);
`endif

endinterface

// File: rtl/fibonacci_seq.sv
// Fibonacci term generator: seeds load while reset is high, one new term per clock after release.
// Defining FIB_OVERFLOW_FLAG_EN adds a sticky carry-out flag (ovf) on the interface.
module fibonacci_seq
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned IDX_W = FIB_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  fibonacci_seq_if.slave   bus
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;

`ifdef FIB_OVERFLOW_FLAG_EN
  logic [WIDTH:0] sum;
  logic           ovf_q, ovf_d;
`else
  logic [WIDTH-1:0] sum;
`endif

  always_comb begin
`ifdef FIB_OVERFLOW_FLAG_EN
    sum = {1'b0, a_q} + {1'b0, b_q};
`else
    sum = a_q + b_q;
`endif
    a_d   = b_q;
    b_d   = sum[WIDTH-1:0];
    idx_d = idx_q + IDX_W'(1);
    if (reset) begin
      a_d   = bus.f0;
      b_d   = bus.f1;
      idx_d = '0;
    end
  end

`ifdef FIB_OVERFLOW_FLAG_EN
  // Sticky: once a carry is seen it holds until the next reset.
  always_comb begin
    ovf_d = ovf_q | sum[WIDTH];
    if (reset) ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
`ifdef FIB_OVERFLOW_FLAG_EN
    ovf_q <= ovf_d;
`endif
  end

  assign bus.fn  = a_q;
  assign bus.idx = idx_q;
`ifdef FIB_OVERFLOW_FLAG_EN
  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/fib_clock_gen.sv
// Simulation-only free-running clock source for fibonacci_seq benches.
module fib_clock_gen
  import fib_pkg::*;
(
  output logic clock
);

  initial clock = 1'b0;
  always #(CLK_PERIOD_NS / 2) clock = ~clock;

endmodule

// File: tb/tb_fibonacci_seq.sv
// Self-checking bench for fibonacci_seq: vector table plus hand-written corner sequences.
// Checks ovf only when built with FIB_OVERFLOW_FLAG_EN.
module tb_fibonacci_seq;
  import fib_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  fibonacci_seq_if #(.WIDTH(FIB_WIDTH), .IDX_W(FIB_IDX_W)) bus ();

  fib_clock_gen u_clk (.clock(clock));

  fibonacci_seq #(.WIDTH(FIB_WIDTH), .IDX_W(FIB_IDX_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic                 rst;
    term_t                f0;
    term_t                f1;
    term_t                fn;
    logic [FIB_IDX_W-1:0] idx;
    logic                 ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic step(input logic r, input term_t s0, input term_t s1);
    reset  = r;
    bus.f0 = s0;
    bus.f1 = s1;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string name, input term_t fn, input logic [FIB_IDX_W-1:0] idx,
                         input logic ovf);
    chk({name, ".fn"}, 32'(bus.fn), 32'(fn));
    chk({name, ".idx"}, 32'(bus.idx), 32'(idx));
`ifdef FIB_OVERFLOW_FLAG_EN
    chk({name, ".ovf"}, 32'(bus.ovf), 32'(ovf));
`else
    if (ovf !== ovf) $display("unreachable");
`endif
  endtask

  initial begin
    term_t exp_a[5];
    term_t hold_f0[5];

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.f0   = '0;
    bus.f1   = '0;

    // Seeds 1,1: full run through the wrap, then a mid-run reset and restart.
    vecs.push_back('{1'b1, 6'd1, 6'd1, 6'd1,  8'd0,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd1,  8'd1,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd2,  8'd2,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd3,  8'd3,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd5,  8'd4,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd8,  8'd5,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd13, 8'd6,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd21, 8'd7,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd34, 8'd8,  1'b0});
    // 34+55 carries out here (b becomes 25), so ovf rises alongside fn=55.
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd55, 8'd9,  1'b1});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd25, 8'd10, 1'b1});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd16, 8'd11, 1'b1});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd41, 8'd12, 1'b1});
    vecs.push_back('{1'b1, 6'd1, 6'd1, 6'd1,  8'd0,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd1,  8'd1,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd2,  8'd2,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd3,  8'd3,  1'b0});
    vecs.push_back('{1'b0, 6'd0, 6'd0, 6'd5,  8'd4,  1'b0});
    vecs.push_back('{1'b1, 6'd1, 6'd1, 6'd1,  8'd0,  1'b0});
    vecs.push_back('{1'b0, 6'd9, 6'd9, 6'd1,  8'd1,  1'b0});
    vecs.push_back('{1'b0, 6'd9, 6'd9, 6'd2,  8'd2,  1'b0});
    vecs.push_back('{1'b0, 6'd9, 6'd9, 6'd3,  8'd3,  1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].f0, vecs[i].f1);
      chk_out($sformatf("vec%0d", i), vecs[i].fn, vecs[i].idx, vecs[i].ovf);
    end

    // Seeds 2,3 with seed inputs scrambled while running.
    exp_a = '{6'd3, 6'd5, 6'd8, 6'd13, 6'd21};
    step(1'b1, 6'd2, 6'd3);
    chk_out("s23_rst", 6'd2, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, term_t'($urandom), term_t'($urandom));
      chk_out($sformatf("s23_%0d", i), exp_a[i], 8'(i + 1), 1'b0);
    end

    // Reset held while f0 moves: fn follows f0, idx pinned at 0.
    hold_f0 = '{6'd7, 6'd9, 6'd4, 6'd12, 6'd30};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, hold_f0[i], 6'd11);
      chk_out($sformatf("hold_%0d", i), hold_f0[i], 8'd0, 1'b0);
    end
    step(1'b0, 6'd0, 6'd0);
    chk_out("hold_rel0", 6'd11, 8'd1, 1'b0);
    step(1'b0, 6'd0, 6'd0);
    chk_out("hold_rel1", 6'd41, 8'd2, 1'b0);

    // Seeds 0,0: fn stays 0; run long enough to see idx wrap past 255.
    step(1'b1, 6'd0, 6'd0);
    chk_out("zero_rst", 6'd0, 8'd0, 1'b0);
    for (int i = 1; i <= 258; i++) begin
      step(1'b0, 6'd63, 6'd63);
      chk_out($sformatf("zero_%0d", i), 6'd0, 8'(i % 256), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
